ccff_loader: RTL and testbench
==============================

# ccff_loader

On-chip configuration-chain driver for the FPGA fabric: accepts the bitstream as words over a valid/ready stream, serializes it MSB-first onto `ccff_head`, and issues a per-cycle shift enable for the configuration chain. A second mode runs a chain-integrity test. The test injects a single '1' marker and checks that it emerges at `ccff_tail` after exactly `CHAIN_LEN` shifts. The block sits between the management-side bitstream source and the fabric's `ccff_head`/`ccff_tail` pins, in the `prog_clk` domain.

## Interface
- `CHAIN_LEN`, 29696: number of configuration flops in the chain, equal to the bitstream size in bits.
- `WORD_W`, 32: input word width.
- `CNT_W`, 16: shift-counter width; must satisfy 2^CNT_W > CHAIN_LEN+2.
- `prog_clk  in  1`: single clock; the chain also runs on this clock.
- `pReset  in  1`: reset, asynchronous, active-low. The chain flops share this reset and clear to 0.
- `start  in  1`: one-cycle request to begin an operation; ignored while `busy`.
- `mode  in  1`: operation select, latched on `start`. 0 = PROGRAM, 1 = TEST.
- `s_data  in  WORD_W`: bitstream word; bit WORD_W-1 is shifted first.
- `s_valid  in  1`: word valid.
- `s_ready  out  1`: word accepted on a cycle where both `s_valid` and `s_ready` are 1.
- `ccff_head  out  1`: serial data driven into the head of the chain.
- `ccff_shift  out  1`: chain advance enable. The chain shifts on each `prog_clk` rising edge that ends a cycle with `ccff_shift`=1.
- `ccff_tail  in  1`: chain output.
- `busy  out  1`: high from the cycle after an accepted `start` until the cycle after `done`.
- `done  out  1`: one-cycle completion pulse.
- `error  out  1`: TEST failure flag; sticky, cleared on an accepted `start`.
- `shift_cnt  out  CNT_W`: number of completed shifts in the current operation.

## Operation
- States: IDLE, PROG, TEST, DONE.
- **IDLE**
  - `start`=1 and `mode`=0 → PROG.
  - `start`=1 and `mode`=1 → TEST.
  - On entry to either: `shift_cnt`←0 and `error`←0.
- **PROG**
  - Holds one shift register of WORD_W bits plus `bits_left`.
  - `s_ready`=1 when `bits_left`==0, or when `bits_left`==1 while shifting. This allows back-to-back words with no bubble.
  - Each cycle with a bit available: drive `ccff_head`=current MSB and `ccff_shift`=1, then shift left.
  - With no bit available: `ccff_shift`=0 (stall), `ccff_head` holds its value, `shift_cnt` holds.
  - The final word uses only its top ((CHAIN_LEN−1) mod WORD_W)+1 bits; the remaining bits are discarded.
  - After shift CHAIN_LEN completes → DONE. `s_ready` is 0 in every cycle after the final word is accepted.
- **TEST**
  - Drives `ccff_shift`=1 for CHAIN_LEN+2 consecutive cycles, with `ccff_head`=1 on the first shift and 0 afterwards. `s_ready`=0 throughout.
  - `ccff_tail` is checked in the cycle where `shift_cnt`=k:
    - k<CHAIN_LEN: tail must be 0.
    - k=CHAIN_LEN: tail must be 1.
    - k=CHAIN_LEN+1 or CHAIN_LEN+2: tail must be 0.
  - Any mismatch sets `error`. After the k=CHAIN_LEN+2 check → DONE.
  - TEST leaves the chain cleared; it is destructive to configuration.
- **DONE**: `done`=1 for one cycle, then → IDLE.
- `start` while `busy` is ignored and the mode is not re-latched. `mode` is ignored outside the `start` cycle.
- `pReset` asserted mid-operation: immediate return to IDLE with every output at its reset value. No `done` pulse is issued and the partial bitstream is discarded.

## Timing
- Reset values: `s_ready`, `ccff_head`, `ccff_shift`, `busy`, `done`, `error` = 0; `shift_cnt`=0.
- Outputs `ccff_head`, `ccff_shift`, `s_ready`, `done` and `busy` are registered. `ccff_head` and `ccff_shift` change together.
- `start` at edge 0 → `busy`=1 after edge 1.
  - TEST: first `ccff_shift`=1 after edge 1.
  - PROG: `s_ready`=1 after edge 1; the first shift happens one cycle after the first accepted word.
- `shift_cnt` increments on the same edge that shifts the chain.
- `ccff_tail` is compared combinationally in the cycle that follows that edge; `error` registers on the next edge.
- With no stalls:
  - PROG: `done` fires CHAIN_LEN+2 cycles after the first word is accepted.
  - TEST: `done` fires CHAIN_LEN+4 cycles after `start`.

## Structure
- Package `ccff_pkg` holds:
  - the state enum (IDLE/PROG/TEST/DONE);
  - mode constants `CCFF_MODE_PROG`=0 and `CCFF_MODE_TEST`=1;
  - a function computing the number of valid bits in the last word.
- Sub-module `ccff_word_shifter` handles word load, MSB-first serialization, the `bits_left` counter and `s_ready` generation.
- The top level holds the FSM, `shift_cnt`, and the tail checker.

## Test plan
- **TEST on healthy chain.** Model CHAIN_LEN=64 flops and apply `start`, `mode`=1. Required: `ccff_tail`=1 only at `shift_cnt`=64, `error`=0, `done` once at cycle 68.
- **TEST on short chain.** Model 63 flops. Required: tail=1 at `shift_cnt`=63 and `error`=1 after `done`.
- **PROG streaming.** Use CHAIN_LEN=80, WORD_W=32 and words 0xDEADBEEF, 0x12345678, 0xA5000000 with `s_valid` held high. Required: the chain holds the 80 MSB-first bits, the 16 discarded bits are never shifted, there are 80 `ccff_shift` cycles, and `s_ready`=0 after the third accept.
- **PROG with stalls.** Drop `s_valid` for 5 cycles mid-stream. Required: `ccff_shift`=0 and `shift_cnt` frozen during the gap, and the final chain contents are identical to the no-stall run.
- **Mid-operation reset.** Pulse `pReset` at `shift_cnt`=30. Required: all outputs 0 and no `done`; a following `start` runs cleanly.
- **`start` during busy.** Pulse `start` with `mode`=1 mid-PROG. Required: ignored; PROG completes normally with `error`=0.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROG = 2'd1,
        ST_TEST = 2'd2,
        ST_DONE = 2'd3
    } ccff_state_t;

    localparam logic CCFF_MODE_PROG = 1'b0;
    localparam logic CCFF_MODE_TEST = 1'b1;

    // Valid bits in the final bitstream word (1..word_w).
    function automatic int unsigned last_word_bits(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return ((chain_len - 1) % word_w) + 1;
    endfunction

    function automatic int unsigned num_words(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Word intake and MSB-first serializer for the PROG bitstream path.
module ccff_word_shifter
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 29696,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              init,
    input  logic              prog_next,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_valid,
    output logic              bit_data
);

    localparam int unsigned LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
    localparam int unsigned N_WORDS   = num_words(CHAIN_LEN, WORD_W);
    localparam int unsigned BL_W      = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg, sreg_n;
    logic [BL_W-1:0]   bits_left, bits_left_n;
    logic [CNT_W-1:0]  words_left, words_left_n;
    logic              accept;

    assign accept = s_valid & s_ready;

    // An accepted word emits its MSB on the accepting edge, so bits_left counts
    // only the bits still waiting behind it; ready at zero gives no bubble.
    always_comb begin
        sreg_n       = sreg;
        bits_left_n  = bits_left;
        words_left_n = words_left;
        bit_valid    = 1'b0;
        bit_data     = sreg[WORD_W-1];
        if (init) begin
            sreg_n       = '0;
            bits_left_n  = '0;
            words_left_n = CNT_W'(N_WORDS);
        end else if (accept) begin
            bit_valid    = 1'b1;
            bit_data     = s_data[WORD_W-1];
            sreg_n       = s_data << 1;
            words_left_n = words_left - CNT_W'(1);
            bits_left_n  = (words_left == CNT_W'(1)) ? BL_W'(LAST_BITS - 1)
                                                     : BL_W'(WORD_W - 1);
        end else if (bits_left != '0) begin
            bit_valid   = 1'b1;
            sreg_n      = sreg << 1;
            bits_left_n = bits_left - BL_W'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sreg       <= '0;
            bits_left  <= '0;
            words_left <= '0;
            s_ready    <= 1'b0;
        end else begin
            sreg       <= sreg_n;
            bits_left  <= bits_left_n;
            words_left <= words_left_n;
            s_ready    <= prog_next && (words_left_n != '0) && (bits_left_n == '0);
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain driver: streams the bitstream into ccff_head or runs a marker integrity test.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 29696,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              mode,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  shift_cnt
);

    localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CHAIN_LEN + 2);

    ccff_state_t      state, state_n;
    logic [CNT_W-1:0] shift_cnt_n;
    logic             head_n, shift_n, error_n;
    logic             init_prog, bit_valid, bit_data;

    ccff_word_shifter #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .init      (init_prog),
        .prog_next (state_n == ST_PROG),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .bit_valid (bit_valid),
        .bit_data  (bit_data)
    );

    always_comb begin
        state_n     = state;
        shift_cnt_n = shift_cnt + {{(CNT_W-1){1'b0}}, ccff_shift};
        head_n      = ccff_head;
        shift_n     = 1'b0;
        error_n     = error;
        init_prog   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    shift_cnt_n = '0;
                    error_n     = 1'b0;
                    if (mode == CCFF_MODE_TEST) begin
                        state_n = ST_TEST;
                        shift_n = 1'b1;
                        head_n  = 1'b1;
                    end else begin
                        state_n   = ST_PROG;
                        init_prog = 1'b1;
                    end
                end
            end
            ST_PROG: begin
                shift_n = bit_valid;
                if (bit_valid) head_n = bit_data;
                if (shift_cnt == CNT_LEN) state_n = ST_DONE;
            end
            ST_TEST: begin
                // Marker must appear at the tail after exactly CHAIN_LEN shifts.
                if (ccff_tail != (shift_cnt == CNT_LEN)) error_n = 1'b1;
                if (shift_cnt == CNT_END) begin
                    state_n = ST_DONE;
                end else begin
                    shift_n = (shift_cnt_n != CNT_END);
                    head_n  = 1'b0;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state      <= ST_IDLE;
            shift_cnt  <= '0;
            ccff_head  <= 1'b0;
            ccff_shift <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shift_cnt  <= shift_cnt_n;
            ccff_head  <= head_n;
            ccff_shift <= shift_n;
            error      <= error_n;
            busy       <= (state_n != ST_IDLE);
            done       <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader against a behavioural chain and bitstream model.
module tb_ccff_loader;
    import ccff_pkg::*;

    localparam int unsigned N  = 80;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b0;
    logic          start    = 1'b0;
    logic          mode     = 1'b0;
    logic [W-1:0]  s_data   = '0;
    logic          s_valid  = 1'b0;
    logic          s_ready, ccff_head, ccff_shift, ccff_tail;
    logic          busy, done, error;
    logic [CW-1:0] shift_cnt;

    ccff_loader #(
        .CHAIN_LEN (N),
        .WORD_W    (W),
        .CNT_W     (CW)
    ) dut (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start),
        .mode       (mode),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ccff_head  (ccff_head),
        .ccff_shift (ccff_shift),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .shift_cnt  (shift_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    int unsigned cyc = 0;
    always @(posedge prog_clk) cyc++;

    // Fabric chain model; its length is adjustable to emulate a broken chain.
    logic [127:0] chain;
    logic [6:0]   tail_idx = 7'(N - 1);
    always @(posedge prog_clk or negedge pReset) begin
        if (!pReset)         chain <= '0;
        else if (ccff_shift) chain <= {chain[126:0], ccff_head};
    end
    assign ccff_tail = chain[tail_idx];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] wq [0:2];

    function automatic logic [127:0] exp_chain();
        logic [127:0] e = '0;
        for (int j = 0; j < int'(N); j++) e[N-1-j] = wq[j / W][W - 1 - (j % W)];
        return e;
    endfunction

    localparam logic [127:0] MASK = (128'd1 << N) - 128'd1;

    task automatic run_test(input int unsigned len, input logic exp_err);
        int unsigned c0, done_cyc = 0, nshift = 0, ones = 0;
        logic [CW-1:0] tail_at = '0;
        bit seen_done = 0;
        tail_idx = 7'(len - 1);
        @(negedge prog_clk);
        start = 1'b1; mode = CCFF_MODE_TEST; c0 = cyc;
        @(negedge prog_clk);
        start = 1'b0;
        chk("test_first_shift", {busy, ccff_shift, ccff_head}, 3'b111);
        for (int k = 0; k < int'(N) + 20; k++) begin
            if (ccff_tail) begin ones++; tail_at = shift_cnt; end
            if (ccff_shift) nshift++;
            if (done) begin seen_done = 1; done_cyc = cyc; break; end
            @(negedge prog_clk);
        end
        chk("test_done_seen", seen_done, 1);
        chk("test_done_cycle", done_cyc - c0, N + 4);
        chk("test_tail_ones", ones, 1);
        chk("test_tail_at", tail_at, len);
        chk("test_nshift", nshift, N + 2);
        chk("test_error", error, exp_err);
        @(negedge prog_clk);
        chk("test_idle", {busy, done, ccff_shift, error}, {3'b000, exp_err});
        tail_idx = 7'(N - 1);
    endtask

    task automatic run_prog(input int gap_at, input bit rand_valid, input int busy_start_at,
                            output logic [127:0] got_chain);
        int unsigned wi = 0, nshift = 0, c_acc = 0, done_cyc = 0, n_idle = 0;
        bit seen_done = 0, late_ready = 0, cnt_bad = 0, v;
        logic [CW-1:0] prev_cnt;
        logic prev_shift;
        s_valid = 1'b0;
        @(negedge prog_clk);
        start = 1'b1; mode = CCFF_MODE_PROG;
        @(negedge prog_clk);
        start = 1'b0;
        chk("prog_start", {busy, s_ready, ccff_shift}, 3'b110);
        prev_cnt = shift_cnt; prev_shift = ccff_shift;
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) begin
                if (shift_cnt !== prev_cnt + {{(CW-1){1'b0}}, prev_shift}) cnt_bad = 1;
                if (ccff_shift) nshift++;
                if (done) begin seen_done = 1; done_cyc = cyc; end
                prev_cnt = shift_cnt; prev_shift = ccff_shift;
            end
            if (wi == 3 && s_ready) late_ready = 1;
            if (seen_done) break;
            v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (gap_at >= 0 && k >= gap_at && k < gap_at + 5) v = 1'b0;
            s_data  = (wi < 3) ? wq[wi] : W'($urandom);
            s_valid = v;
            if (v && s_ready && wi < 3) begin
                if (wi == 0) c_acc = cyc;
                wi++;
            end else if (!v && s_ready && wi > 0 && wi < 3) begin
                n_idle++;
            end
            start = (k == busy_start_at);
            mode  = (k == busy_start_at) ? CCFF_MODE_TEST : CCFF_MODE_PROG;
            @(negedge prog_clk);
        end
        s_valid = 1'b0; start = 1'b0;
        chk("prog_done_seen", seen_done, 1);
        chk("prog_done_cycle", done_cyc - c_acc, N + 2 + n_idle);
        chk("prog_nshift", nshift, N);
        chk("prog_cnt_step", cnt_bad, 0);
        chk("prog_ready_after_last", late_ready, 0);
        chk("prog_error", error, 0);
        got_chain = chain & MASK;
        chk("prog_chain", got_chain, exp_chain());
        @(negedge prog_clk);
        chk("prog_idle", {busy, done, s_ready}, 3'b000);
        chk("prog_final_cnt", shift_cnt, N);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] c1, c2, c3;
        bit bad;
        repeat (2) @(negedge prog_clk);
        chk("reset_outputs", {s_ready, ccff_head, ccff_shift, busy, done, error, shift_cnt}, '0);
        pReset = 1'b1;
        @(negedge prog_clk);

        run_test(N, 1'b0);
        run_test(N - 1, 1'b1);

        wq[0] = 32'hDEADBEEF; wq[1] = 32'h12345678; wq[2] = 32'hA5000000;
        run_prog(-1, 1'b0, -1, c1);
        run_prog(62, 1'b0, -1, c2);
        chk("stall_same_chain", c2, c1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) wq[i] = $urandom;
            run_prog(-1, 1'b1, (r == 0) ? 20 : -1, c3);
        end

        // Reset mid-stream.
        @(negedge prog_clk);
        start = 1'b1; mode = CCFF_MODE_PROG;
        @(negedge prog_clk);
        start = 1'b0; s_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            s_data = W'($urandom);
            if (shift_cnt == CW'(30)) break;
            @(negedge prog_clk);
        end
        chk("rst_reached_30", shift_cnt, 30);
        #2 pReset = 1'b0;
        #1 chk("rst_outputs", {s_ready, ccff_head, ccff_shift, busy, done, error, shift_cnt}, '0);
        s_valid = 1'b0;
        repeat (2) @(negedge prog_clk);
        pReset = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge prog_clk);
            if (done || busy) bad = 1;
        end
        chk("rst_no_done", bad, 0);
        run_test(N, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
